// File: rtl/am_pkg.sv
// Shared constants and helpers for the transmit alignment-marker inserter:
// default per-lane marker bytes, the marker sync header and the BIP position map.
package am_pkg;

    localparam int AM_BYTES_W = 48;

    // Per lane {M6,M5,M4,M2,M1,M0}, M0 in the low byte; lane 0 is the low slice.
    localparam logic [4*AM_BYTES_W-1:0] AM_DEFAULT = {
        48'hC2_86_5D_3D_79_A2,
        48'h64_9A_3A_9B_65_C5,
        48'h19_3B_0F_E6_C4_F0,
        48'hB8_89_6F_47_76_90
    };

    localparam logic [1:0] AM_HEAD = 2'b01;

    function automatic logic [7:0] block_bip(input logic [1:0] head, input logic [63:0] data);
        logic [7:0] bip;
        bip = '0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                bip[k] = bip[k] ^ data[k + 8*j];
            end
        end
        // Sync header bits fold into BIP bits 3 and 4.
        bip[3] = bip[3] ^ head[0];
        bip[4] = bip[4] ^ head[1];
        return bip;
    endfunction

endpackage

// File: rtl/am_bip_lane.sv
// One lane of the marker inserter: keeps the running BIP for the lane and
// forms the lane's marker block from its marker bytes and the accumulated parity.
module am_bip_lane
    import am_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        emit_data_i,
    input  logic        emit_marker_i,
    input  logic [47:0] marker_i,
    input  logic [1:0]  head_i,
    input  logic [63:0] data_i,
    output logic [1:0]  am_head_o,
    output logic [63:0] am_data_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    assign am_head_o = AM_HEAD;
    assign am_data_o = {~acc_q, marker_i[47:24], acc_q, marker_i[23:0]};

    // A marker restarts the parity with its own map, so each period covers
    // the previous marker plus the data blocks that follow it.
    always_comb begin
        acc_d = acc_q;
        if (emit_marker_i) begin
            acc_d = block_bip(AM_HEAD, am_data_o);
        end else if (emit_data_i) begin
            acc_d = acc_q ^ block_bip(head_i, data_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/am_bip_tx.sv
// Transmit alignment-marker inserter: passes scrambled blocks through with one
// cycle of latency and inserts a per-lane marker with BIP after every GAP_N blocks.
module am_bip_tx
    import am_pkg::*;
#(
    parameter int LANE_N = 4,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64,
    parameter int GAP_N  = 16383,
    parameter logic [LANE_N*AM_BYTES_W-1:0] MARKER = AM_DEFAULT[LANE_N*AM_BYTES_W-1:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    input  logic [LANE_N*DATA_W-1:0] data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic                     marker_v_o,
    output logic [LANE_N*HEAD_W-1:0] head_o,
    output logic [LANE_N*DATA_W-1:0] data_o
);

    localparam int CNT_W = $clog2(GAP_N + 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pending_q, pending_d;
    logic                     valid_q, valid_d;
    logic                     marker_v_q, marker_v_d;
    logic [LANE_N*HEAD_W-1:0] head_q, head_d;
    logic [LANE_N*DATA_W-1:0] data_q, data_d;
    logic [LANE_N*HEAD_W-1:0] am_head;
    logic [LANE_N*DATA_W-1:0] am_data;
    logic                     accept;

    assign ready_o    = ~pending_q;
    assign accept     = valid_i & ~pending_q;
    assign valid_o    = valid_q;
    assign marker_v_o = marker_v_q;
    assign head_o     = head_q;
    assign data_o     = data_q;

    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        am_bip_lane u_lane (
            .clk           (clk),
            .reset         (reset),
            .emit_data_i   (accept),
            .emit_marker_i (pending_q),
            .marker_i      (MARKER[i*AM_BYTES_W +: AM_BYTES_W]),
            .head_i        (head_i[i*HEAD_W +: HEAD_W]),
            .data_i        (data_i[i*DATA_W +: DATA_W]),
            .am_head_o     (am_head[i*HEAD_W +: HEAD_W]),
            .am_data_o     (am_data[i*DATA_W +: DATA_W])
        );
    end

    // A pending marker owns the output slot; upstream is held off via ready_o.
    always_comb begin
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        valid_d    = 1'b0;
        marker_v_d = 1'b0;
        head_d     = head_q;
        data_d     = data_q;
        if (pending_q) begin
            pending_d  = 1'b0;
            valid_d    = 1'b1;
            marker_v_d = 1'b1;
            head_d     = am_head;
            data_d     = am_data;
        end else if (valid_i) begin
            valid_d = 1'b1;
            head_d  = head_i;
            data_d  = data_i;
            if (cnt_q == CNT_W'(GAP_N - 1)) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            marker_v_q <= 1'b0;
            head_q     <= '0;
            data_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            marker_v_q <= marker_v_d;
            head_q     <= head_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_am_bip_tx.sv
// Bench for am_bip_tx: a 4-lane and a 2-lane instance share stimulus and are
// checked against a behavioural marker/BIP model through an expectation queue.
module tb_am_bip_tx;

    localparam int GAP_N  = 4;
    localparam int LANE_N = 4;

    // Marker bytes per lane in the order M0,M1,M2,M4,M5,M6.
    localparam logic [7:0] AM_BYTES [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
    };

    typedef struct {
        logic         valid;
        logic         mark;
        logic [7:0]   head;
        logic [255:0] data;
    } exp_t;

    typedef struct {
        logic         valid;
        logic [7:0]   head;
        logic [255:0] data;
        logic         exp_ready;
        logic         exp_valid;
        logic         exp_mark;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_i = 1'b0;
    logic [7:0]   head_i = '0;
    logic [255:0] data_i = '0;
    logic         ready_o, valid_o, marker_v_o;
    logic [7:0]   head_o;
    logic [255:0] data_o;
    logic         ready2, valid2, mark2;
    logic [3:0]   head2;
    logic [127:0] data2;

    int n_checks = 0;
    int n_fail   = 0;

    int           m_cnt;
    logic         m_pend;
    logic [7:0]   m_acc [4];
    logic [7:0]   m_head;
    logic [255:0] m_data;
    exp_t         sb_q [$];

    always #5 clk = ~clk;

    am_bip_tx #(.LANE_N(LANE_N), .HEAD_W(2), .DATA_W(64), .GAP_N(GAP_N)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .head_i(head_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .marker_v_o(marker_v_o),
        .head_o(head_o), .data_o(data_o)
    );

    am_bip_tx #(.LANE_N(2), .HEAD_W(2), .DATA_W(64), .GAP_N(GAP_N)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .head_i(head_i[3:0]), .data_i(data_i[127:0]),
        .ready_o(ready2), .valid_o(valid2), .marker_v_o(mark2),
        .head_o(head2), .data_o(data2)
    );

    // Walks all 66 block bits and drops each into its BIP bit.
    function automatic logic [7:0] ref_bip(input logic [1:0] h, input logic [63:0] d);
        logic [65:0] blk;
        logic [7:0]  r;
        blk = {d, h};
        r = '0;
        for (int b = 0; b < 66; b++) begin
            if (blk[b]) begin
                if (b == 0)      r[3] = ~r[3];
                else if (b == 1) r[4] = ~r[4];
                else             r[(b-2)%8] = ~r[(b-2)%8];
            end
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_pend = 1'b0;
        m_head = '0;
        m_data = '0;
        for (int l = 0; l < 4; l++) m_acc[l] = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] h, input logic [255:0] d, output exp_t e);
        logic [63:0] md;
        e.valid = 1'b0;
        e.mark  = 1'b0;
        if (m_pend) begin
            for (int l = 0; l < 4; l++) begin
                md = {~m_acc[l], AM_BYTES[l][5], AM_BYTES[l][4], AM_BYTES[l][3],
                      m_acc[l], AM_BYTES[l][2], AM_BYTES[l][1], AM_BYTES[l][0]};
                m_data[l*64 +: 64] = md;
                m_head[l*2 +: 2]   = 2'b01;
                m_acc[l]           = ref_bip(2'b01, md);
            end
            m_pend  = 1'b0;
            e.valid = 1'b1;
            e.mark  = 1'b1;
        end else if (v) begin
            m_head = h;
            m_data = d;
            for (int l = 0; l < 4; l++) m_acc[l] = m_acc[l] ^ ref_bip(h[l*2 +: 2], d[l*64 +: 64]);
            m_cnt++;
            if (m_cnt == GAP_N) begin
                m_cnt  = 0;
                m_pend = 1'b1;
            end
            e.valid = 1'b1;
        end
        e.head = m_head;
        e.data = m_data;
    endtask

    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            cmp("valid_o", valid_o, e.valid);
            cmp("marker_v_o", marker_v_o, e.mark);
            cmp("head_o", head_o, e.head);
            cmp("data_o", data_o, e.data);
            cmp("valid_o_l2", valid2, e.valid);
            cmp("marker_v_o_l2", mark2, e.mark);
            cmp("head_o_l2", head2, e.head[3:0]);
            cmp("data_o_l2", data2, e.data[127:0]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply_stimulus(input logic v, input logic [7:0] h, input logic [255:0] d);
        exp_t e;
        valid_i = v;
        head_i  = h;
        data_i  = d;
        cmp("ready_o", ready_o, !m_pend);
        cmp("ready_o_l2", ready2, !m_pend);
        model_step(v, h, d, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        exp_t e;
        reset   = 1'b1;
        valid_i = 1'b0;
        model_reset();
        e.valid = 1'b0;
        e.mark  = 1'b0;
        e.head  = '0;
        e.data  = '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [255:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rand_head();
        logic [7:0] h;
        for (int l = 0; l < 4; l++) h[l*2 +: 2] = 2'($urandom_range(1, 2));
        return h;
    endfunction

    vec_t tbl [10];

    initial begin
        for (int i = 0; i < 10; i++) begin
            tbl[i].valid     = (i % 2 == 0) || (i == 8);
            tbl[i].head      = rand_head();
            tbl[i].data      = rand_data();
            tbl[i].exp_ready = (i != 7);
            tbl[i].exp_valid = (i % 2 == 0) || (i == 7) || (i == 8);
            tbl[i].exp_mark  = (i == 7);
        end

        @(negedge clk);
        reset_cycle();
        reset_cycle();
        cmp("ready_after_reset", ready_o, 1'b1);

        // Zero data: first marker carries zero parity.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'h00, '0);
        cmp("marker_flag_zero", marker_v_o, 1'b1);
        cmp("marker_lane0_zero", data_o[63:0], 64'hFFB8896F00477690);

        // One set data bit and one set header bit on lane 0.
        reset_cycle();
        apply_stimulus(1'b1, 8'h01, 256'h1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'h00, '0);
        apply_stimulus(1'b1, 8'h00, '0);
        cmp("bip3_single", data_o[31:24], 8'h09);
        cmp("bip7_single", data_o[63:56], 8'hF6);

        // Alternating valid: only accepted blocks advance toward the marker.
        reset_cycle();
        for (int i = 0; i < 10; i++) begin
            cmp("tbl_ready", ready_o, tbl[i].exp_ready);
            apply_stimulus(tbl[i].valid, tbl[i].head, tbl[i].data);
            cmp("tbl_valid", valid_o, tbl[i].exp_valid);
            cmp("tbl_mark", marker_v_o, tbl[i].exp_mark);
        end

        // Three back-to-back periods of random traffic.
        reset_cycle();
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, rand_head(), rand_data());

        // Reset while a marker is pending discards it.
        reset_cycle();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, rand_head(), rand_data());
        cmp("pending_ready", ready_o, 1'b0);
        reset_cycle();
        cmp("ready_after_pend_reset", ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, rand_head(), rand_data());
            cmp("no_early_marker", marker_v_o, 1'b0);
        end
        apply_stimulus(1'b1, rand_head(), rand_data());
        cmp("marker_after_reset", marker_v_o, 1'b1);
        apply_stimulus(1'b0, 8'h00, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
